alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issue/retire controller that drives a WIDTH-bit two's-complement ALU and consumes its results. It accepts instructions over a valid/ready handshake and reads operands from an internal register file. It presents operands, carry-in and opcode to the ALU, then captures the result, carry-out and flags and writes them back. It sits between the instruction source and the combinational ALU and owns all architectural state: registers and flags.

Parameters:
WIDTH, 8, datapath width; must match the attached ALU
NREGS, 4, register count, power of two, >= 2
RW, $clog2(NREGS), register index width (derived; not overridden)

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept
instr_op  in  4  opcode (alu_pkg::opcode)
instr_rd / instr_ra / instr_rb  in  RW each  destination / operand A / operand B register
instr_use_imm  in  1  1: operand B = instr_imm
instr_imm  in  WIDTH  immediate
alu_a / alu_b  out  WIDTH  ALU operands
alu_c_in  out  1  ALU carry-in
alu_op  out  4  ALU opcode
alu_res  in  WIDTH  ALU result
alu_c_out, alu_zero, alu_neg, alu_ovf, alu_par  in  1 each  ALU carry-out and flags
flags  out  5  {C,V,N,Z,P} architectural flags
wb_valid  out  1  one-cycle retire pulse
wb_rd  out  RW  retired destination
wb_data  out  WIDTH  retired value
dbg_addr  in  RW  debug read address
dbg_data  out  WIDTH  regs[dbg_addr], combinational

Behaviour:
- FSM states: IDLE, EXEC, RETIRE.
- instr_ready = 1 in IDLE and RETIRE, 0 in EXEC.
- Accept when instr_valid && instr_ready. On that edge:
  - latch op_a = regs[ra];
  - latch op_b = use_imm ? imm : regs[rb];
  - latch op and rd;
  - go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_op are driven from the latches; alu_c_in = flags.C.
  - On the exiting edge: regs[rd] <= alu_res; flags <= {alu_c_out, alu_ovf, alu_neg, alu_zero, alu_par}; wb_rd/wb_data latched; go to RETIRE.
- RETIRE:
  - wb_valid = 1 for exactly this cycle.
  - Accepting a new instruction here goes to EXEC; otherwise go to IDLE.
- Timing:
  - Latency: accept edge to regs/flags update is 2 edges; wb_valid is high in the cycle after the update.
  - Peak throughput is one instruction per 2 cycles.
- Hazards: an instruction accepted in RETIRE reads the already-updated register file and flags. No forwarding is needed and no stale read is allowed.
- All 16 opcodes are legal, and every opcode writes rd and all five flags (see optional feature).
- Outside EXEC, alu_op = PASSTHROUGH, and alu_a/alu_b hold their last latched values.
- Reset values:
  - state IDLE;
  - all regs = 0, flags = 0;
  - wb_valid = 0, wb_rd = 0, wb_data = 0;
  - alu_a = alu_b = 0, alu_op = PASSTHROUGH.
- Reset mid-operation: the in-flight instruction is discarded. No wb_valid, no register/flag write.
- instr_* are ignored while instr_ready = 0. The source holds them stable until accepted.

Optional Feature:
ALU_SEQ_PRESERVE_CV_EN
- Defined: for PASSTHROUGH, BIT_AND, BIT_OR, BIT_XOR and BIT_NOT, the C and V flags keep their prior values; N, Z and P update normally.
- Undefined: all five flags update on every retire.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[3:0] opcode: PASSTHROUGH=0, ADD=1, ADD_WITH_CIN=2, SUBTRACT=3, SUB_WITH_CIN=4, TWOS_COMPLEMENT=5, INCREMENT=6, DECREMENT=7, BIT_AND=8, BIT_OR=9, BIT_XOR=10, BIT_NOT=11, ASR=12, LSR=13, SHIFT_LEFT=14, ROTATE=15;
  - the flag-index localparams FLAG_C=4, FLAG_V=3, FLAG_N=2, FLAG_Z=1, FLAG_P=0;
  - the FSM state typedef.
- One sub-module: alu_regfile (NREGS x WIDTH, three combinational read ports ra/rb/dbg, one synchronous write port, async active-low clear).

Test Plan:
1. Reset with rst_n low 3 cycles, then release -> instr_ready=1, flags=5'b0, dbg_data=0 for every address, wb_valid=0.
2. PASSTHROUGH rd=1, imm=8'h7F, use_imm=1 -> alu_op=0000 and alu_a=regs[1]=0, alu_b=8'h7F while in EXEC. Retire 2 edges after accept with wb_rd=1, wb_data=ALU result (alu_a passed through, i.e. 8'h00 on this first load). Drive the external ALU model accordingly; r1 matches wb_data.
3. With r1=8'h7F, ADD rd=2 ra=1 imm=1 -> alu_a=8'h7F, alu_b=8'h01, alu_op=0001 -> r2=8'h80, flags C=0 V=1 N=1 Z=0 P=1.
4. Carry chain: ADD FF+01 -> flags C=1, Z=1. Next, ADD_WITH_CIN 00+00 -> alu_c_in=1 in its EXEC cycle, result 8'h01, C=0.
5. instr_valid held high with two dependent instructions (second reads first's rd) -> accepts at cycles 0 and 2, wb_valid at cycles 2 and 4. The second instruction's alu_a equals the first's result.
6. rst_n asserted during EXEC -> no wb_valid, destination register and flags remain 0. With ALU_SEQ_PRESERVE_CV_EN defined, BIT_AND after C=1 leaves C=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types plus flag bit positions shared by the ALU sequencer
package alu_pkg;

   typedef enum logic [3:0] {
      PASSTHROUGH     = 4'd0,
      ADD             = 4'd1,
      ADD_WITH_CIN    = 4'd2,
      SUBTRACT        = 4'd3,
      SUB_WITH_CIN    = 4'd4,
      TWOS_COMPLEMENT = 4'd5,
      INCREMENT       = 4'd6,
      DECREMENT       = 4'd7,
      BIT_AND         = 4'd8,
      BIT_OR          = 4'd9,
      BIT_XOR         = 4'd10,
      BIT_NOT         = 4'd11,
      ASR             = 4'd12,
      LSR             = 4'd13,
      SHIFT_LEFT      = 4'd14,
      ROTATE          = 4'd15
   } opcode;

   localparam int FLAG_C = 4;
   localparam int FLAG_V = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_P = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RETIRE = 2'd2
   } seq_state;

   // Logical and move operations have no meaningful carry/overflow of their own
   function automatic logic keeps_cv(input opcode op);
      return op inside {PASSTHROUGH, BIT_AND, BIT_OR, BIT_XOR, BIT_NOT};
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x WIDTH register file, two operand read ports, one debug read port, one write port
module alu_regfile #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [RW-1:0]    wa_i,
   input  logic [WIDTH-1:0] wd_i,
   input  logic [RW-1:0]    ra_i,
   input  logic [RW-1:0]    rb_i,
   input  logic [RW-1:0]    dbg_i,
   output logic [WIDTH-1:0] ra_data_o,
   output logic [WIDTH-1:0] rb_data_o,
   output logic [WIDTH-1:0] dbg_data_o
);

   logic [WIDTH-1:0] regs_q [NREGS];

   // Storage: cleared on reset, one register written per retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         regs_q <= '{default: '0};
      else if (we_i)
         regs_q[wa_i] <= wd_i;
   end

   assign ra_data_o  = regs_q[ra_i];
   assign rb_data_o  = regs_q[rb_i];
   assign dbg_data_o = regs_q[dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/retire controller owning registers and flags around an external ALU (option: ALU_SEQ_PRESERVE_CV_EN)
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_op,
   input  logic [RW-1:0]    instr_rd,
   input  logic [RW-1:0]    instr_ra,
   input  logic [RW-1:0]    instr_rb,
   input  logic             instr_use_imm,
   input  logic [WIDTH-1:0] instr_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_c_in,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_c_out,
   input  logic             alu_zero,
   input  logic             alu_neg,
   input  logic             alu_ovf,
   input  logic             alu_par,
   output logic [4:0]       flags,
   output logic             wb_valid,
   output logic [RW-1:0]    wb_rd,
   output logic [WIDTH-1:0] wb_data,
   input  logic [RW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   seq_state         state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   opcode            op_q;
   logic [RW-1:0]    rd_q, wb_rd_q;
   logic [WIDTH-1:0] wb_data_q;
   logic [4:0]       flags_q, flags_d;
   logic [WIDTH-1:0] ra_data, rb_data;
   logic             accept, keep_cv;

   assign instr_ready = state_q != EXEC;
   assign accept      = instr_valid && instr_ready;

   alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (state_q == EXEC),
      .wa_i       (rd_q),
      .wd_i       (alu_res),
      .ra_i       (instr_ra),
      .rb_i       (instr_rb),
      .dbg_i      (dbg_addr),
      .ra_data_o  (ra_data),
      .rb_data_o  (rb_data),
      .dbg_data_o (dbg_data)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state: EXEC always retires; IDLE and RETIRE both accept straight into EXEC
   always_comb begin
      state_d = IDLE;
      state_d = (state_q == EXEC) ? RETIRE : (accept ? EXEC : IDLE);
   end

   // Next flags from the ALU, optionally holding C/V across logical operations
   always_comb begin
`ifdef ALU_SEQ_PRESERVE_CV_EN
      keep_cv = keeps_cv(op_q);
`else
      keep_cv = 1'b0;
`endif
      flags_d         = {alu_c_out, alu_ovf, alu_neg, alu_zero, alu_par};
      flags_d[FLAG_C] = keep_cv ? flags_q[FLAG_C] : alu_c_out;
      flags_d[FLAG_V] = keep_cv ? flags_q[FLAG_V] : alu_ovf;
   end

   // Operand latch on accept; flag and writeback capture on leaving EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_q      <= PASSTHROUGH;
         rd_q      <= '0;
         flags_q   <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         if (accept) begin
            op_a_q <= ra_data;
            op_b_q <= instr_use_imm ? instr_imm : rb_data;
            op_q   <= opcode'(instr_op);
            rd_q   <= instr_rd;
         end
         if (state_q == EXEC) begin
            flags_q   <= flags_d;
            wb_rd_q   <= rd_q;
            wb_data_q <= alu_res;
         end
      end
   end

   assign alu_a    = op_a_q;
   assign alu_b    = op_b_q;
   assign alu_op   = (state_q == EXEC) ? op_q : PASSTHROUGH;
   assign alu_c_in = flags_q[FLAG_C];
   assign flags    = flags_q;
   assign wb_valid = state_q == RETIRE;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural 8-bit ALU attached
module tb_alu_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_op = 4'd0;
   logic [1:0] instr_rd = 2'd0, instr_ra = 2'd0, instr_rb = 2'd0;
   logic       instr_use_imm = 1'b0;
   logic [7:0] instr_imm = 8'd0;
   logic [7:0] alu_a, alu_b, alu_res;
   logic       alu_c_in;
   logic [3:0] alu_op;
   logic       alu_c_out, alu_zero, alu_neg, alu_ovf, alu_par;
   logic [4:0] flags;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [7:0] wb_data;
   logic [1:0] dbg_addr = 2'd0;
   logic [7:0] dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic       cin;
      logic [1:0] rd;
      logic [7:0] data;
      logic [4:0] fl;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] regs_m [4];
   logic [4:0] flags_m;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(8), .NREGS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
      .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_op(alu_op),
      .alu_res(alu_res), .alu_c_out(alu_c_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .alu_ovf(alu_ovf), .alu_par(alu_par),
      .flags(flags), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Reference ALU: returns {C,V,N,Z,P,result}
   function automatic logic [12:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
      logic [8:0] t;
      logic [7:0] r;
      logic       c, v;
      t = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         PASSTHROUGH:     r = a;
         ADD:             begin t = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (t[7] != a[7]); end
         ADD_WITH_CIN:    begin t = {1'b0, a} + {1'b0, b} + {8'd0, ci}; v = (a[7] == b[7]) && (t[7] != a[7]); end
         SUBTRACT:        begin t = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (t[7] != a[7]); end
         SUB_WITH_CIN:    begin t = {1'b0, a} - {1'b0, b} - {8'd0, ci}; v = (a[7] != b[7]) && (t[7] != a[7]); end
         TWOS_COMPLEMENT: begin t = 9'd0 - {1'b0, a}; v = (a == 8'h80); end
         INCREMENT:       begin t = {1'b0, a} + 9'd1; v = (a == 8'h7F); end
         DECREMENT:       begin t = {1'b0, a} - 9'd1; v = (a == 8'h80); end
         BIT_AND:         r = a & b;
         BIT_OR:          r = a | b;
         BIT_XOR:         r = a ^ b;
         BIT_NOT:         r = ~a;
         ASR:             begin r = {a[7], a[7:1]}; c = a[0]; end
         LSR:             begin r = {1'b0, a[7:1]}; c = a[0]; end
         SHIFT_LEFT:      begin t = {a, 1'b0}; v = a[7] ^ a[6]; end
         default:         begin r = {a[6:0], a[7]}; c = a[7]; end
      endcase
      if (op inside {[1:7], 14}) begin
         r = t[7:0];
         c = t[8];
      end
      return {c, v, r[7], r == 8'd0, ^r, r};
   endfunction

   assign {alu_c_out, alu_ovf, alu_neg, alu_zero, alu_par, alu_res} = alu_f(alu_op, alu_a, alu_b, alu_c_in);

   // Drive one instruction, predict its outcome from the architectural model and queue it
   task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                       input logic ui, input logic [7:0] imm, input bit hold);
      exp_t        e;
      logic [12:0] r;
      @(negedge clk);
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
      instr_use_imm = ui; instr_imm = imm;
      e.a   = regs_m[ra];
      e.b   = ui ? imm : regs_m[rb];
      e.op  = op;
      e.cin = flags_m[4];
      r     = alu_f(op, e.a, e.b, e.cin);
      e.rd  = rd;
      e.data = r[7:0];
      e.fl  = r[12:8];
`ifdef ALU_SEQ_PRESERVE_CV_EN
      if (op inside {4'd0, 4'd8, 4'd9, 4'd10, 4'd11}) e.fl[4:3] = flags_m[4:3];
`endif
      regs_m[rd] = e.data;
      flags_m    = e.fl;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) instr_valid = 1'b0;
   endtask

   // Scoreboard head vs the ALU-facing outputs during EXEC
   task automatic sb_exec();
      exp_t e;
      n_tests++;
      if (sbq.size() == 0) begin
         n_fail++; $display("FAIL sb_exec: scoreboard empty, required an outstanding instruction");
         return;
      end
      e = sbq[0];
      n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL exec_ready: got %b want 0", instr_ready); end
      n_tests++; if (alu_op !== e.op)      begin n_fail++; $display("FAIL exec_op: got %h want %h", alu_op, e.op); end
      n_tests++; if (alu_a !== e.a)        begin n_fail++; $display("FAIL exec_a: got %h want %h", alu_a, e.a); end
      n_tests++; if (alu_b !== e.b)        begin n_fail++; $display("FAIL exec_b: got %h want %h", alu_b, e.b); end
      n_tests++; if (alu_c_in !== e.cin)   begin n_fail++; $display("FAIL exec_cin: got %b want %b", alu_c_in, e.cin); end
   endtask

   // Advance to the retire cycle, pop the scoreboard and compare writeback, flags and register contents
   task automatic sb_retire();
      exp_t e;
      @(posedge clk);
      #1;
      n_tests++;
      if (sbq.size() == 0) begin
         n_fail++; $display("FAIL sb_retire: scoreboard empty, required an outstanding instruction");
         return;
      end
      e = sbq.pop_front();
      n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid: got %b want 1", wb_valid); end
      n_tests++; if (wb_rd !== e.rd)    begin n_fail++; $display("FAIL wb_rd: got %0d want %0d", wb_rd, e.rd); end
      n_tests++; if (wb_data !== e.data) begin n_fail++; $display("FAIL wb_data: got %h want %h", wb_data, e.data); end
      n_tests++; if (flags !== e.fl)    begin n_fail++; $display("FAIL flags: got %b want %b", flags, e.fl); end
      dbg_addr = e.rd;
      #1;
      n_tests++; if (dbg_data !== e.data) begin n_fail++; $display("FAIL reg_wb r%0d: got %h want %h", e.rd, dbg_data, e.data); end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) regs_m[i] = 8'd0;
      flags_m = 5'd0;
      sbq.delete();
   endtask

   task automatic test_reset();
      clear_model();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
      n_tests++; if (flags !== 5'd0)       begin n_fail++; $display("FAIL rst_flags: got %b want 00000", flags); end
      n_tests++; if (wb_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      n_tests++; if (wb_data !== 8'd0 || wb_rd !== 2'd0) begin n_fail++; $display("FAIL rst_wb: got rd %0d data %h want 0/00", wb_rd, wb_data); end
      n_tests++; if (alu_op !== 4'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin n_fail++; $display("FAIL rst_alu: got op %h a %h b %h want 0/00/00", alu_op, alu_a, alu_b); end
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         n_tests++; if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL rst_reg r%0d: got %h want 00", i, dbg_data); end
      end
   endtask

   task automatic test_passthrough();
      send(PASSTHROUGH, 2'd1, 2'd1, 2'd0, 1'b1, 8'h7F, 1'b0);
      sb_exec();
      sb_retire();
      n_tests++; if (wb_data !== 8'h00) begin n_fail++; $display("FAIL pass_first_load: got %h want 00", wb_data); end
      @(posedge clk);
      #1;
      n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL pass_pulse: got %b want 0", wb_valid); end
   endtask

   task automatic test_add_flags();
      send(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b0);
      sb_exec();
      sb_retire();
      send(ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0);
      sb_exec();
      sb_retire();
      n_tests++; if (wb_data !== 8'h80 || flags !== 5'b01101) begin n_fail++; $display("FAIL add_ovf: got %h/%b want 80/01101", wb_data, flags); end
   endtask

   task automatic test_carry_chain();
      send(ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b0);
      sb_exec();
      sb_retire();
      send(ADD, 2'd3, 2'd3, 2'd0, 1'b1, 8'h01, 1'b0);
      sb_exec();
      sb_retire();
      n_tests++; if (flags !== 5'b10010) begin n_fail++; $display("FAIL carry_out: got %b want 10010", flags); end
      send(ADD_WITH_CIN, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0);
      n_tests++; if (alu_c_in !== 1'b1) begin n_fail++; $display("FAIL carry_in: got %b want 1", alu_c_in); end
      sb_exec();
      sb_retire();
      n_tests++; if (wb_data !== 8'h01 || flags[FLAG_C] !== 1'b0) begin n_fail++; $display("FAIL adc_result: got %h C=%b want 01 C=0", wb_data, flags[FLAG_C]); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] first;
      send(INCREMENT, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1);
      first = regs_m[2];
      sb_exec();
      sb_retire();
      n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_retire: got %b want 1", instr_ready); end
      send(SHIFT_LEFT, 2'd3, 2'd2, 2'd0, 1'b0, 8'h00, 1'b0);
      n_tests++; if (alu_a !== first) begin n_fail++; $display("FAIL b2b_dependent_a: got %h want %h", alu_a, first); end
      sb_exec();
      sb_retire();
   endtask

   task automatic test_all_ops();
      for (int i = 0; i < 16; i++) begin
         send(4'(i), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), i < 15);
         sb_exec();
         sb_retire();
      end
   endtask

   task automatic test_reset_mid_exec();
      send(BIT_OR, 2'd3, 2'd0, 2'd0, 1'b1, 8'h5A, 1'b0);
      n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_exec: got ready %b want 0", instr_ready); end
      #2;
      rst_n = 1'b0;
      clear_model();
      repeat (2) begin
         @(posedge clk);
         #1;
         n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wb_valid: got %b want 0", wb_valid); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wb_after: got %b want 0", wb_valid); end
      end
      dbg_addr = 2'd3;
      #1;
      n_tests++; if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL mid_reg: got %h want 00", dbg_data); end
      n_tests++; if (flags !== 5'd0)    begin n_fail++; $display("FAIL mid_flags: got %b want 00000", flags); end
   endtask

   task automatic test_logic_cv();
      send(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b0);
      sb_exec();
      sb_retire();
      send(ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0);
      sb_exec();
      sb_retire();
      send(BIT_AND, 2'd2, 2'd3, 2'd0, 1'b1, 8'hFF, 1'b0);
      sb_exec();
      sb_retire();
`ifdef ALU_SEQ_PRESERVE_CV_EN
      n_tests++; if (flags[FLAG_C] !== 1'b1) begin n_fail++; $display("FAIL and_keeps_c: got %b want 1", flags[FLAG_C]); end
`else
      n_tests++; if (flags[FLAG_C] !== 1'b0) begin n_fail++; $display("FAIL and_clears_c: got %b want 0", flags[FLAG_C]); end
`endif
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_add_flags();
      test_carry_chain();
      test_back_to_back();
      test_all_ops();
      test_reset_mid_exec();
      test_logic_cv();
      n_tests++;
      if (sbq.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d entries left, want 0", sbq.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
